// File: rtl/bsmm_operand_loader_if.sv
// Operand-loader bus: stream input from host/DMA plus the vector/launch side to the multiplier.
// No logic, wiring only. Flow control is valid/ready on the stream side.
// Framing ports in_last/frame_err exist only when BSMM_LOADER_LAST_CHECK_EN is defined.
interface bsmm_operand_loader_if #(
    parameter int N_VALUES = 10,
    parameter int WIDTH    = 32
);
    logic [WIDTH-1:0]                in_data;
    logic                            in_valid;
    logic                            in_ready;
    logic [N_VALUES-1:0][WIDTH-1:0]  values;
    logic                            start;
    logic                            busy;
`ifdef BSMM_LOADER_LAST_CHECK_EN
    logic                            in_last;
    logic                            frame_err;

    modport slave  (input  in_data, in_valid, in_last,
                    output in_ready, values, start, busy, frame_err);
    modport master (output in_data, in_valid, in_last,
                    input  in_ready, values, start, busy, frame_err);
`else
    modport slave  (input  in_data, in_valid,
                    output in_ready, values, start, busy);
    modport master (output in_data, in_valid,
                    input  in_ready, values, start, busy);
`endif
endinterface

// File: rtl/bsmm_operand_loader.sv
// Assembles N_VALUES stream words into the multiplier operand vector, then pulses start.
// Latency: start one cycle after the last accept; vector frozen for COMPUTE_CYCLES cycles after that.
// Backpressure: in_ready low from FIRE through WAIT; optional framing check under BSMM_LOADER_LAST_CHECK_EN.
module bsmm_operand_loader #(
    parameter int N_VALUES       = 10,
    parameter int WIDTH          = 32,
    parameter int COMPUTE_CYCLES = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bsmm_operand_loader_if.slave bus
);
    localparam int IW = $clog2(N_VALUES);
    localparam int CW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_VALUES - 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(COMPUTE_CYCLES - 1);

    typedef enum logic [1:0] {S_FILL, S_FIRE, S_WAIT} state_t;

    state_t                         state_q, state_d;
    logic [IW-1:0]                  idx_q;
    logic [CW-1:0]                  cnt_q;
    logic [N_VALUES-1:0][WIDTH-1:0] values_q;
    logic                           ready_q;
    logic                           busy_q;
    logic                           start_c;
    logic                           xfer;
    logic                           frm_bad;

    // ready_q is only ever high in FILL, so a transfer implies FILL.
    assign xfer = bus.in_valid & ready_q;

`ifdef BSMM_LOADER_LAST_CHECK_EN
    logic err_q;
    assign frm_bad       = xfer & (bus.in_last != (idx_q == LAST_IDX));
    assign bus.frame_err = err_q;
`else
    assign frm_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL: if (xfer && idx_q == LAST_IDX && !frm_bad) state_d = S_FIRE;
            S_FIRE: state_d = S_WAIT;
            S_WAIT: if (cnt_q == '0) state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    always_comb begin
        start_c = 1'b0;
        if (state_q == S_FIRE) start_c = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            cnt_q    <= '0;
            values_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef BSMM_LOADER_LAST_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            // Handshake flags look ahead so they line up with the state they describe.
            ready_q <= (state_d == S_FILL);
            busy_q  <= (state_d != S_FILL);
            if (xfer) begin
                values_q[idx_q] <= bus.in_data;
                if (idx_q == LAST_IDX || frm_bad) idx_q <= '0;
                else                              idx_q <= idx_q + IW'(1);
            end
            if (state_q == S_FIRE)                   cnt_q <= CNT_INIT;
            else if (state_q == S_WAIT && cnt_q != '0) cnt_q <= cnt_q - CW'(1);
`ifdef BSMM_LOADER_LAST_CHECK_EN
            err_q <= frm_bad;
`endif
        end
    end

    assign bus.in_ready = ready_q;
    assign bus.busy     = busy_q;
    assign bus.start    = start_c;
    assign bus.values   = values_q;

endmodule

// File: tb/tb_bsmm_operand_loader.sv
// Directed bench for bsmm_operand_loader: driver pushes expected frames, a negedge monitor pops and checks.
// Framing-error scenario is included when BSMM_LOADER_LAST_CHECK_EN is defined.
module tb_bsmm_operand_loader;
    localparam int N  = 10;
    localparam int W  = 32;
    localparam int C  = 40;
    localparam int VW = N * W;

    typedef logic [N-1:0][W-1:0] vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   last_acc;

    vec_t exp_q[$];
    int   exp_cyc_q[$];
    int   err_cyc_q[$];

    bsmm_operand_loader_if #(.N_VALUES(N), .WIDTH(W)) bus ();

    bsmm_operand_loader #(.N_VALUES(N), .WIDTH(W), .COMPUTE_CYCLES(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send_word(input logic [W-1:0] d, input bit last, input int gap);
        bit ok;
        int to;
        repeat (gap) @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
`ifdef BSMM_LOADER_LAST_CHECK_EN
        bus.in_last  = last;
`else
        if (last) ok = 1'b0;
`endif
        to = 0;
        forever begin
            @(negedge clk);
            ok       = bus.in_ready;
            last_acc = cyc;
            @(posedge clk);
            if (ok) break;
            to++;
            if (to > 200) begin
                chk("accept_timeout", 1, 0);
                break;
            end
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input vec_t fr, input int maxgap, input int first);
        for (int i = first; i < N; i++)
            send_word(fr[i], i == N - 1, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        exp_q.push_back(fr);
        exp_cyc_q.push_back(last_acc + 1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready && !bus.busy) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 1, 0);
        @(posedge clk);
    endtask

    // Monitor: start pops the scoreboard; the busy window is measured from start.
    initial begin
        bit   win;
        int   blen;
        int   rlow;
        vec_t e;
        int   ec;
        bit   prev_err;
        win = 1'b0; blen = 0; rlow = 0; prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                win = 1'b0;
                prev_err = 1'b0;
            end else begin
                if (win) begin
                    if (bus.busy) begin
                        blen++;
                        if (!bus.in_ready) rlow++;
                    end else begin
                        chk("busy_len", VW'(blen), VW'(C + 1));
                        chk("ready_low_len", VW'(rlow), VW'(C + 1));
                        chk("ready_return", VW'(bus.in_ready), VW'(1));
                        win = 1'b0;
                    end
                end
                if (bus.start) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_start", VW'(cyc), '1);
                    end else begin
                        e  = exp_q.pop_front();
                        ec = exp_cyc_q.pop_front();
                        chk("values", bus.values, e);
                        chk("values8", VW'(bus.values[8]), VW'(e[8]));
                        chk("values9", VW'(bus.values[9]), VW'(e[9]));
                        chk("start_cycle", VW'(cyc), VW'(ec));
                    end
                    win  = 1'b1;
                    blen = bus.busy ? 1 : 0;
                    rlow = bus.in_ready ? 0 : 1;
                end
`ifdef BSMM_LOADER_LAST_CHECK_EN
                if (bus.frame_err) begin
                    if (prev_err) chk("frame_err_width", 2, 1);
                    if (err_cyc_q.size() == 0) chk("unexpected_frame_err", VW'(cyc), '1);
                    else chk("frame_err_cycle", VW'(cyc), VW'(err_cyc_q.pop_front()));
                end
                prev_err = bus.frame_err;
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   f1[N];
        vec_t fa;
        vec_t fb;
        int   k;
        bit   seen;
        f1 = '{1, 3, 5, 19, 24, 12, 23, 135, -23, 20};
        for (int i = 0; i < N; i++) begin
            fa[i] = W'(f1[i]);
            fb[i] = W'(32'h100 + i * 32'h11);
        end
        checks = 0; errors = 0; last_acc = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
`ifdef BSMM_LOADER_LAST_CHECK_EN
        bus.in_last  = 1'b0;
`endif
        // Reset state and in_ready release timing.
        repeat (3) @(negedge clk);
        chk("rst_values", bus.values, '0);
        chk("rst_start", VW'(bus.start), 0);
        chk("rst_busy", VW'(bus.busy), 0);
        chk("rst_ready", VW'(bus.in_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", VW'(bus.in_ready), 0);
        @(negedge clk);
        chk("ready_after_release", VW'(bus.in_ready), 1);
        chk("busy_after_release", VW'(bus.busy), 0);
        @(posedge clk);

        // Back-to-back frame, then the same frame with random gaps.
        chk("neg23_encoding", VW'(fa[8]), VW'(32'hFFFFFFE9));
        send_frame(fa, 0, 0);
        wait_idle();
        send_frame(fb, 3, 0);
        wait_idle();
        send_frame(fa, 3, 0);
        wait_idle();

        // Word offered from the start cycle onward waits for in_ready.
        send_frame(fb, 0, 0);
        k = last_acc;
        send_word(32'd7, 1'b0, 0);
        chk("held_word_accept_cycle", VW'(last_acc), VW'(k + C + 2));
        fa[0] = 32'd7;
        send_frame(fa, 0, 1);
        wait_idle();

        // Reset in the middle of WAIT.
        fa[0] = 32'd1;
        send_frame(fb, 0, 0);
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (bus.start) seen = 1'b1;
        end
        chk("start_seen_before_reset", VW'(seen), 1);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midwait_rst_values", bus.values, '0);
        chk("midwait_rst_busy", VW'(bus.busy), 0);
        chk("midwait_rst_start", VW'(bus.start), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_ready", VW'(bus.in_ready), 1);
        chk("post_rst_busy", VW'(bus.busy), 0);
        @(posedge clk);
        send_frame(fa, 0, 0);
        wait_idle();

`ifdef BSMM_LOADER_LAST_CHECK_EN
        // Early in_last on the fourth word aborts the frame.
        for (int i = 0; i < 4; i++) send_word(fb[i], i == 3, 0);
        err_cyc_q.push_back(last_acc + 1);
        repeat (3) @(negedge clk);
        chk("err_no_busy", VW'(bus.busy), 0);
        chk("err_partial_kept", VW'(bus.values[3]), VW'(fb[3]));
        @(posedge clk);
        send_frame(fa, 1, 0);
        wait_idle();
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", VW'(exp_q.size()), 0);
        chk("err_queue_drained", VW'(err_cyc_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
